// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI reader: frame FSM states,
// the LED command byte and the per-byte TX pattern.
package jstk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } jstk_state_e;

    localparam logic [7:0] JSTK_LED_CMD     = 8'h80;
    localparam int         JSTK_FRAME_BYTES = 5;

    // Byte 0 carries the LED command, every other byte is a dummy zero.
    function automatic logic [7:0] jstk_tx_byte(input logic [2:0] idx, input logic [1:0] led);
        logic [7:0] b;
        if (idx == 3'd0) begin
            b = JSTK_LED_CMD | {6'b000000, led};
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

endpackage

// File: rtl/jstk_spi_byte.sv
// One 8-bit SPI mode-0 transfer, MSB first. SCLK idles low; MOSI shifts and
// MISO is captured on the cycle SCLK is driven low.
module jstk_spi_byte
    import jstk_pkg::*;
#(
    parameter int SCLK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx_byte
);
    localparam int            HW        = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);
    localparam logic [HW-1:0] HALF_ONE  = HW'(1'b1);

    logic [HW-1:0] half_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    tx_sh_r;
    logic [7:0]    rx_sh_r;
    logic          sclk_r;
    logic          mosi_r;
    logic          busy_r;
    logic          miso_meta_r;
    logic          miso_sync_r;
    logic          half_end_s;
    logic          fall_s;

    assign half_end_s = busy_r && (half_cnt_r == HALF_LAST);
    assign fall_s     = half_end_s && sclk_r;
    assign done       = fall_s && (bit_cnt_r == 3'd7);
    // The completed byte includes the bit being captured on the final falling edge.
    assign rx_byte    = {rx_sh_r[6:0], miso_sync_r};
    assign sclk       = sclk_r;
    assign mosi       = mosi_r;

    // Two-flop synchroniser for the asynchronous MISO pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
        end else begin
            miso_meta_r <= miso;
            miso_sync_r <= miso_meta_r;
        end
    end

    // SCLK half-period timing and TX/RX shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            half_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            tx_sh_r    <= 8'h00;
            rx_sh_r    <= 8'h00;
        end else if (start && !busy_r) begin
            busy_r     <= 1'b1;
            half_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            sclk_r     <= 1'b0;
            tx_sh_r    <= tx_byte;
            mosi_r     <= tx_byte[7];
        end else if (busy_r) begin
            if (half_end_s) begin
                half_cnt_r <= '0;
                if (!sclk_r) begin
                    sclk_r <= 1'b1;
                end else begin
                    sclk_r  <= 1'b0;
                    rx_sh_r <= {rx_sh_r[6:0], miso_sync_r};
                    if (bit_cnt_r == 3'd7) begin
                        busy_r <= 1'b0;
                        mosi_r <= 1'b0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        tx_sh_r   <= {tx_sh_r[6:0], 1'b0};
                        mosi_r    <= tx_sh_r[6];
                    end
                end
            end else begin
                half_cnt_r <= half_cnt_r + HALF_ONE;
            end
        end
    end

endmodule

// File: rtl/jstk_spi_reader.sv
// PmodJSTK poller: every POLL_CYC cycles runs a 5-byte SPI frame and publishes
// the decoded X/Y/button values with a one-cycle data_valid pulse.
module jstk_spi_reader
    import jstk_pkg::*;
#(
    parameter int SCLK_DIV     = 100,
    parameter int SS_LEAD_CYC  = 1500,
    parameter int BYTE_GAP_CYC = 1000,
    parameter int POLL_CYC     = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  led,
    input  logic        miso,
    output logic        ss_n,
    output logic        sclk,
    output logic        mosi,
    output logic [10:0] x_val,
    output logic [9:0]  y_val,
    output logic [2:0]  btn,
    output logic        data_valid
);
    localparam int            PW        = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);
    localparam logic [PW-1:0] POLL_ONE  = PW'(1'b1);
    localparam int            CMAX      = (SS_LEAD_CYC > BYTE_GAP_CYC) ? SS_LEAD_CYC : BYTE_GAP_CYC;
    localparam int            CW        = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LEAD_LAST = CW'(SS_LEAD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BYTE_GAP_CYC - 1);
    localparam logic [CW-1:0] PH_ONE    = CW'(1'b1);
    localparam logic [2:0]    LAST_BYTE = 3'(JSTK_FRAME_BYTES - 1);

    jstk_state_e   state_r, state_nxt_s;
    logic [PW-1:0] poll_cnt_r;
    logic [CW-1:0] phase_cnt_r;
    logic [2:0]    byte_idx_r;
    logic [1:0]    led_r;
    logic [7:0]    x_lo_r, y_lo_r;
    logic [1:0]    x_hi_r, y_hi_r;
    logic [2:0]    btn_buf_r;
    logic          ss_n_r, data_valid_r;
    logic [10:0]   x_val_r;
    logic [9:0]    y_val_r;
    logic [2:0]    btn_r;
    logic          poll_wrap_s, start_s, byte_done_s, frame_go_s;
    logic [7:0]    rx_byte_s;

    assign poll_wrap_s = (poll_cnt_r == POLL_LAST);
    assign frame_go_s  = (state_r == IDLE) && (state_nxt_s == LEAD);

    jstk_spi_byte #(.SCLK_DIV(SCLK_DIV)) u_byte (
        .clk     (clk),
        .rst_n   (rst),
        .start   (start_s),
        .tx_byte (jstk_tx_byte(byte_idx_r, led_r)),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .done    (byte_done_s),
        .rx_byte (rx_byte_s)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame sequencing: a timer wrap outside IDLE is simply dropped.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (poll_wrap_s && enable) state_nxt_s = LEAD;
                else                       state_nxt_s = IDLE;
            end
            LEAD: begin
                if (phase_cnt_r == LEAD_LAST) begin
                    state_nxt_s = SHIFT;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = LEAD;
                end
            end
            SHIFT: begin
                if (byte_done_s) state_nxt_s = (byte_idx_r == LAST_BYTE) ? DONE : GAP;
                else             state_nxt_s = SHIFT;
            end
            GAP: begin
                if (phase_cnt_r == GAP_LAST) begin
                    state_nxt_s = SHIFT;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Free-running poll timer, per-state phase counter, byte index and LED sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt_r  <= '0;
            phase_cnt_r <= '0;
            byte_idx_r  <= 3'd0;
            led_r       <= 2'b00;
        end else begin
            poll_cnt_r  <= poll_wrap_s ? '0 : poll_cnt_r + POLL_ONE;
            phase_cnt_r <= (state_nxt_s != state_r) ? '0 : phase_cnt_r + PH_ONE;
            if (frame_go_s) begin
                byte_idx_r <= 3'd0;
                led_r      <= led;
            end else if (byte_done_s) begin
                byte_idx_r <= byte_idx_r + 3'd1;
            end
        end
    end

    // Keep only the meaningful bits of each received byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_lo_r    <= 8'h00;
            x_hi_r    <= 2'b00;
            y_lo_r    <= 8'h00;
            y_hi_r    <= 2'b00;
            btn_buf_r <= 3'b000;
        end else if (byte_done_s) begin
            case (byte_idx_r)
                3'd0:    x_lo_r    <= rx_byte_s;
                3'd1:    x_hi_r    <= rx_byte_s[1:0];
                3'd2:    y_lo_r    <= rx_byte_s;
                3'd3:    y_hi_r    <= rx_byte_s[1:0];
                3'd4:    btn_buf_r <= rx_byte_s[2:0];
                default: btn_buf_r <= btn_buf_r;
            endcase
        end
    end

    // Chip select and atomic publication of the decoded frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_n_r       <= 1'b1;
            x_val_r      <= 11'h000;
            y_val_r      <= 10'h000;
            btn_r        <= 3'b000;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= (state_r == DONE);
            if (frame_go_s) begin
                ss_n_r <= 1'b0;
            end else if (state_r == DONE) begin
                ss_n_r  <= 1'b1;
                x_val_r <= {1'b0, x_hi_r, x_lo_r};
                y_val_r <= {y_hi_r, y_lo_r};
                btn_r   <= btn_buf_r;
            end
        end
    end

    assign ss_n       = ss_n_r;
    assign x_val      = x_val_r;
    assign y_val      = y_val_r;
    assign btn        = btn_r;
    assign data_valid = data_valid_r;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Directed bench for jstk_spi_reader with a mode-0 slave model and a scoreboard
// of expected frame results; timing parameters are scaled down to keep runs short.
module tb_jstk_spi_reader;
    localparam int SCLK_DIV     = 4;
    localparam int SS_LEAD_CYC  = 12;
    localparam int BYTE_GAP_CYC = 8;
    localparam int POLL_CYC     = 600;
    localparam int BYTE_CYC     = 16 * SCLK_DIV;
    localparam int FRAME_CYC    = SS_LEAD_CYC + 5 * BYTE_CYC + 4 * BYTE_GAP_CYC + 1;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [2:0]  b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  led = 2'b00;
    logic        noise = 1'b0;
    logic        slave_miso = 1'b0;
    logic        miso_w;
    logic        ss_n, sclk, mosi, data_valid;
    logic [10:0] x_val;
    logic [9:0]  y_val;
    logic [2:0]  btn;

    assign miso_w = slave_miso ^ noise;

    jstk_spi_reader #(
        .SCLK_DIV(SCLK_DIV), .SS_LEAD_CYC(SS_LEAD_CYC),
        .BYTE_GAP_CYC(BYTE_GAP_CYC), .POLL_CYC(POLL_CYC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .led(led), .miso(miso_w),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .x_val(x_val), .y_val(y_val),
        .btn(btn), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / slave model state
    logic [39:0] slave_frame = 40'h0;
    logic [39:0] slave_sh = 40'h0;
    logic [39:0] mosi_cap = 40'h0;
    logic ss_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0, dv_prev = 1'b0;
    int ss_falls = 0, ss_fall_cyc = 0, ss_rise_cyc = 0;
    int rise_n = 0, fall_n = 0;
    int rise_cyc[40];
    int fall_cyc[40];
    int dv_count = 0, dv_high = 0, dv_cyc = 0;
    int mosi_glitch = 0, sclk_bad = 0;

    always @(negedge clk) begin
        if (ss_prev && !ss_n) begin
            ss_fall_cyc = cyc;
            ss_falls++;
            rise_n = 0;
            fall_n = 0;
            mosi_cap = 40'h0;
            slave_sh = slave_frame;
            slave_miso = slave_sh[39];
        end
        if (!ss_prev && ss_n) ss_rise_cyc = cyc;
        if (!sclk_prev && sclk) begin
            if (rise_n < 40) rise_cyc[rise_n] = cyc;
            rise_n++;
            mosi_cap = {mosi_cap[38:0], mosi};
        end
        if (sclk_prev && !sclk) begin
            if (fall_n < 40) fall_cyc[fall_n] = cyc;
            fall_n++;
            slave_sh = {slave_sh[38:0], 1'b0};
            slave_miso = slave_sh[39];
        end
        if (sclk && sclk_prev && (mosi != mosi_prev)) mosi_glitch++;
        if (sclk && ss_n) sclk_bad++;
        if (data_valid) begin
            dv_high++;
            if (!dv_prev) begin
                dv_count++;
                dv_cyc = cyc;
            end
        end
        ss_prev = ss_n;
        sclk_prev = sclk;
        mosi_prev = mosi;
        dv_prev = data_valid;
    end

    int checks = 0;
    int failures = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ss_fall(input int budget, input string tag);
        int c0 = ss_falls;
        int n = 0;
        while (ss_falls == c0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(ss_falls != c0), 64'd1);
    endtask

    task automatic wait_dv(input int budget, input string tag);
        int c0 = dv_count;
        int n = 0;
        while (dv_count == c0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(dv_count != c0), 64'd1);
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int n = 0;
        while (rise_n < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(rise_n >= target), 64'd1);
    endtask

    task automatic compare_sb(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_x_val"}, 64'(x_val), 64'(e.x));
            check({tag, "_y_val"}, 64'(y_val), 64'(e.y));
            check({tag, "_btn"}, 64'(btn), 64'(e.b));
        end
        check({tag, "_dv_single_cycle"}, 64'(dv_high), 64'(dv_count));
    endtask

    task automatic push_exp(input logic [10:0] x, input logic [9:0] y, input logic [2:0] b);
        exp_t e;
        e.x = x;
        e.y = y;
        e.b = b;
        sb_q.push_back(e);
    endtask

    initial begin
        int rel_cyc, fa, fc, falls0, dv0;
        enable = 1'b1;
        led = 2'b10;

        // Reset held low with MISO toggling
        for (int i = 0; i < 20; i++) begin
            tick();
            noise = ~noise;
        end
        check("rst_ss_n", 64'(ss_n), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_x_val", 64'(x_val), 64'd0);
        check("rst_y_val", 64'(y_val), 64'd0);
        check("rst_no_dv", 64'(dv_count), 64'd0);
        noise = 1'b0;

        // Frame A: basic decode and SPI timing
        slave_frame = {8'h2A, 8'h03, 8'hFF, 8'h01, 8'h05};
        push_exp(11'h32A, 10'h1FF, 3'b101);
        rel_cyc = cyc;
        rst = 1'b1;
        wait_ss_fall(POLL_CYC + 50, "frameA_start");
        check("first_frame_delay", 64'(ss_fall_cyc - rel_cyc), 64'(POLL_CYC));
        fa = ss_fall_cyc;
        wait_dv(FRAME_CYC + 50, "frameA_dv");
        compare_sb("frameA");
        check("lead_to_first_rise", 64'(rise_cyc[0] - fa), 64'(SS_LEAD_CYC + SCLK_DIV));
        check("sclk_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'(2 * SCLK_DIV));
        check("gap_b0_b1", 64'(rise_cyc[8] - fall_cyc[7]), 64'(BYTE_GAP_CYC + SCLK_DIV));
        check("gap_b3_b4", 64'(rise_cyc[32] - fall_cyc[31]), 64'(BYTE_GAP_CYC + SCLK_DIV));
        check("sclk_rises", 64'(rise_n), 64'd40);
        check("mosi_frame", 64'(mosi_cap), 64'h82_0000_0000);
        check("frame_length", 64'(ss_rise_cyc - fa), 64'(FRAME_CYC));
        check("dv_with_ss_rise", 64'(dv_cyc), 64'(ss_rise_cyc));

        // Frame B: upper bits of b1/b3/b4 ignored, outputs held between frames
        slave_frame = {8'h5C, 8'hFE, 8'h37, 8'hFD, 8'hF8};
        push_exp(11'h25C, 10'h137, 3'b000);
        wait_ss_fall(POLL_CYC, "frameB_start");
        check("poll_period", 64'(ss_fall_cyc - fa), 64'(POLL_CYC));
        check("x_val_held", 64'(x_val), 64'h32A);
        wait_dv(FRAME_CYC + 50, "frameB_dv");
        compare_sb("frameB");

        // Frame C: enable dropped during byte 2
        slave_frame = {8'h11, 8'h02, 8'h22, 8'h00, 8'h03};
        push_exp(11'h211, 10'h022, 3'b011);
        wait_ss_fall(POLL_CYC, "frameC_start");
        fc = ss_fall_cyc;
        wait_rises(17, FRAME_CYC, "frameC_byte2");
        enable = 1'b0;
        wait_dv(FRAME_CYC, "frameC_dv");
        compare_sb("frameC");
        falls0 = ss_falls;
        dv0 = dv_count;
        while (cyc < fc + 3 * POLL_CYC + 100) tick();
        check("disabled_no_frame", 64'(ss_falls), 64'(falls0));
        check("disabled_no_dv", 64'(dv_count), 64'(dv0));
        check("disabled_ss_high", 64'(ss_n), 64'd1);

        // Frame D: re-enable, start aligned to the running timer
        slave_frame = {8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF};
        push_exp(11'h3FF, 10'h300, 3'b111);
        enable = 1'b1;
        wait_ss_fall(POLL_CYC + 50, "frameD_start");
        check("reenable_start", 64'(ss_fall_cyc - fc), 64'(4 * POLL_CYC));
        wait_dv(FRAME_CYC + 50, "frameD_dv");
        compare_sb("frameD");

        // Frame E: reset during byte 3 abandons the frame
        slave_frame = {8'h55, 8'h01, 8'h66, 8'h02, 8'h07};
        wait_ss_fall(POLL_CYC + 50, "frameE_start");
        wait_rises(25, FRAME_CYC, "frameE_byte3");
        dv0 = dv_count;
        rst = 1'b0;
        #2;
        check("midrst_ss_n", 64'(ss_n), 64'd1);
        check("midrst_sclk", 64'(sclk), 64'd0);
        check("midrst_x_val", 64'(x_val), 64'd0);
        check("midrst_y_val", 64'(y_val), 64'd0);
        check("midrst_btn", 64'(btn), 64'd0);
        repeat (5) tick();
        rel_cyc = cyc;
        rst = 1'b1;
        wait_ss_fall(POLL_CYC + 50, "postrst_start");
        check("postrst_delay", 64'(ss_fall_cyc - rel_cyc), 64'(POLL_CYC));
        check("midrst_no_dv", 64'(dv_count), 64'(dv0));
        check("postrst_x_val", 64'(x_val), 64'd0);
        check("sclk_only_with_ss", 64'(sclk_bad), 64'd0);
        check("mosi_stable_high", 64'(mosi_glitch), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
